// File: rtl/aibnd_dll_code_gen.sv
// DLL delay-code generator: steps a 10-bit coarse/fine setting from phase-detector
// decisions and drives it gray-coded, changing the codes only while code_valid is low.
module aibnd_dll_code_gen #(
  parameter logic [9:0] INIT_CODE  = 10'd512,
  parameter int         SETTLE_CYC = 4,
  parameter int         PD_WAIT    = 8,
  parameter int         LOCK_CNT   = 4
) (
  input  logic       ck,
  input  logic       nrst,
  input  logic       enable,
  input  logic       pd_valid,
  input  logic       pd_up,
  input  logic       pd_dn,
  input  logic       force_en,
  input  logic [9:0] force_code,
  output logic [6:0] f_gray,
  output logic [2:0] i_gray,
  output logic       code_valid,
  output logic       locked,
  output logic [9:0] code_bin
);

  typedef enum logic [1:0] {IDLE, DROP, SETTLE, WAIT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYC);
  localparam logic [7:0] WAIT_N   = 8'(PD_WAIT);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);

  function automatic logic [9:0] step_sat(input logic [9:0] c, input logic up);
    logic signed [11:0] nxt;
    nxt = $signed({2'b00, c}) + (up ? 12'sd1 : -12'sd1);
    if (nxt > 12'sd1023) return 10'd1023;
    if (nxt < 12'sd0)    return 10'd0;
    return nxt[9:0];
  endfunction

  function automatic logic [6:0] gray7(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t     state_q, state_n;
  dir_t       dir_q, dir_n, step_dir;
  logic [7:0] cnt_q, cnt_n;
  logic [3:0] rev_q, rev_n;
  logic [9:0] code_q, code_n, pend_q, pend_n;
  logic [6:0] f_gray_q, f_gray_n;
  logic [2:0] i_gray_q, i_gray_n;
  logic       valid_q, valid_n, locked_q, locked_n, step;

  assign step     = enable & pd_valid & (pd_up ^ pd_dn);
  assign step_dir = pd_up ? DIR_UP : DIR_DN;

  always_comb begin
    state_n  = state_q;
    dir_n    = dir_q;
    cnt_n    = cnt_q;
    rev_n    = rev_q;
    code_n   = code_q;
    pend_n   = pend_q;
    f_gray_n = f_gray_q;
    i_gray_n = i_gray_q;
    valid_n  = valid_q;
    locked_n = locked_q;
    case (state_q)
      IDLE: begin
        if (force_en) begin
          state_n  = DROP;
          valid_n  = 1'b0;
          pend_n   = force_code;
          locked_n = 1'b0;
          rev_n    = 4'd0;
        end else if (step) begin
          state_n = DROP;
          valid_n = 1'b0;
          pend_n  = step_sat(code_q, pd_up);
          dir_n   = step_dir;
          // A reversal is only a change from a known previous direction.
          if (dir_q != DIR_NONE && dir_q != step_dir)
            rev_n = (rev_q >= LOCK_N) ? LOCK_N : rev_q + 4'd1;
          else
            rev_n = 4'd0;
          locked_n = (rev_n == LOCK_N);
        end
      end
      DROP: begin
        code_n   = pend_q;
        f_gray_n = gray7(pend_q[9:3]);
        i_gray_n = gray3(pend_q[2:0]);
        state_n  = SETTLE;
        cnt_n    = SETTLE_N;
      end
      SETTLE: begin
        if (cnt_q <= 8'd1) begin
          valid_n = 1'b1;
          state_n = WAIT;
          cnt_n   = WAIT_N;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      WAIT: begin
        if (cnt_q <= 8'd1) state_n = IDLE;
        else               cnt_n   = cnt_q - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!nrst) begin
      state_q  <= SETTLE;
      dir_q    <= DIR_NONE;
      cnt_q    <= SETTLE_N;
      rev_q    <= 4'd0;
      code_q   <= INIT_CODE;
      f_gray_q <= gray7(INIT_CODE[9:3]);
      i_gray_q <= gray3(INIT_CODE[2:0]);
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      dir_q    <= dir_n;
      cnt_q    <= cnt_n;
      rev_q    <= rev_n;
      code_q   <= code_n;
      f_gray_q <= f_gray_n;
      i_gray_q <= i_gray_n;
      valid_q  <= valid_n;
      locked_q <= locked_n;
    end
  end

  // Pending load is only consumed in DROP, which reset never enters directly.
  always_ff @(posedge ck) pend_q <= pend_n;

  assign f_gray     = f_gray_q;
  assign i_gray     = i_gray_q;
  assign code_valid = valid_q;
  assign locked     = locked_q;
  assign code_bin   = code_q;

endmodule

// File: tb/tb_aibnd_dll_code_gen.sv
// Directed bench for aibnd_dll_code_gen: scoreboarded code updates, valid-pulse
// timing, saturation, lock/unlock, and reset behaviour.
module tb_aibnd_dll_code_gen;

  logic       ck = 1'b0;
  logic       nrst, enable, pd_valid, pd_up, pd_dn, force_en;
  logic [9:0] force_code;
  logic [6:0] f_gray;
  logic [2:0] i_gray;
  logic       code_valid, locked;
  logic [9:0] code_bin;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb[$];

  aibnd_dll_code_gen dut (
    .ck(ck), .nrst(nrst), .enable(enable), .pd_valid(pd_valid), .pd_up(pd_up),
    .pd_dn(pd_dn), .force_en(force_en), .force_code(force_code), .f_gray(f_gray),
    .i_gray(i_gray), .code_valid(code_valid), .locked(locked), .code_bin(code_bin)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] g7(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] g3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic clear_in();
    pd_valid = 1'b0; pd_up = 1'b0; pd_dn = 1'b0; force_en = 1'b0;
  endtask

  // One full event from IDLE: strobe, DROP, SETTLE (4), WAIT (8), back in IDLE.
  task automatic do_event(input string tag, input bit up, input bit dn, input bit frc,
                          input logic [9:0] fcode, input logic [9:0] exp_code,
                          input bit exp_lock, input bit inject);
    logic [9:0] pre_code, e;
    sb.push_back(exp_code);
    pre_code   = code_bin;
    pd_valid   = !frc;
    pd_up      = up;
    pd_dn      = dn;
    force_en   = frc;
    force_code = fcode;
    tick();
    clear_in();
    chk({tag, "_drop"}, 32'(code_valid), 32'd0);
    chk({tag, "_lock"}, 32'(locked), 32'(exp_lock));
    chk({tag, "_hold"}, 32'(code_bin), 32'(pre_code));
    tick();
    e = sb.pop_front();
    chk({tag, "_code"}, 32'(code_bin), 32'(e));
    chk({tag, "_fg"}, 32'(f_gray), 32'(g7(e[9:3])));
    chk({tag, "_ig"}, 32'(i_gray), 32'(g3(e[2:0])));
    chk({tag, "_lowE1"}, 32'(code_valid), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk({tag, "_lowE3"}, 32'(code_valid), 32'd0);
    tick();
    chk({tag, "_vret"}, 32'(code_valid), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 1) begin
        pd_valid = 1'b1; pd_up = 1'b1; force_en = 1'b1; force_code = 10'd100;
      end
      tick();
      clear_in();
    end
    if (inject) begin
      chk({tag, "_wait_v"}, 32'(code_valid), 32'd1);
      chk({tag, "_wait_c"}, 32'(code_bin), 32'(e));
    end
  endtask

  initial begin
    nrst = 1'b0; enable = 1'b1; force_code = 10'd0;
    clear_in();
    for (int i = 0; i < 3; i++) tick();
    chk("rst_code", 32'(code_bin), 32'd512);
    chk("rst_fg", 32'(f_gray), 32'h60);
    chk("rst_ig", 32'(i_gray), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_lock", 32'(locked), 32'd0);
    nrst = 1'b1;
    // valid rises SETTLE_CYC edges after the last reset edge
    for (int i = 0; i < 3; i++) tick();
    chk("rel_low", 32'(code_valid), 32'd0);
    tick();
    chk("rel_valid", 32'(code_valid), 32'd1);
    for (int i = 0; i < 8; i++) tick();

    do_event("up1", 1, 0, 0, 10'd0, 10'd513, 0, 1);
    chk("up1_ig", 32'(i_gray), 32'h1);

    do_event("f7", 0, 0, 1, 10'd7, 10'd7, 0, 0);
    chk("f7_fg", 32'(f_gray), 32'h00);
    chk("f7_ig", 32'(i_gray), 32'h4);
    do_event("carry", 1, 0, 0, 10'd0, 10'd8, 0, 0);
    chk("carry_fg", 32'(f_gray), 32'h01);
    chk("carry_ig", 32'(i_gray), 32'h0);

    do_event("f1023", 0, 0, 1, 10'd1023, 10'd1023, 0, 0);
    do_event("satup", 1, 0, 0, 10'd0, 10'd1023, 0, 0);
    do_event("f0", 0, 0, 1, 10'd0, 10'd0, 0, 0);
    do_event("satdn", 0, 1, 0, 10'd0, 10'd0, 0, 0);

    do_event("same", 0, 1, 0, 10'd0, 10'd0, 0, 0);
    do_event("rev1", 1, 0, 0, 10'd0, 10'd1, 0, 0);
    do_event("rev2", 0, 1, 0, 10'd0, 10'd0, 0, 0);
    do_event("rev3", 1, 0, 0, 10'd0, 10'd1, 0, 0);
    do_event("rev4", 0, 1, 0, 10'd0, 10'd0, 1, 0);
    do_event("rev5", 1, 0, 0, 10'd0, 10'd1, 1, 0);
    do_event("same2", 1, 0, 0, 10'd0, 10'd2, 0, 0);
    do_event("r1", 0, 1, 0, 10'd0, 10'd1, 0, 0);
    do_event("r2", 1, 0, 0, 10'd0, 10'd2, 0, 0);
    do_event("r3", 0, 1, 0, 10'd0, 10'd1, 0, 0);
    do_event("r4", 1, 0, 0, 10'd0, 10'd2, 1, 0);
    do_event("fclr", 0, 0, 1, 10'd512, 10'd512, 0, 0);

    enable = 1'b0;
    pd_valid = 1'b1; pd_up = 1'b1;
    tick();
    clear_in();
    tick();
    chk("dis_valid", 32'(code_valid), 32'd1);
    chk("dis_code", 32'(code_bin), 32'd512);
    enable = 1'b1;

    pd_valid = 1'b1; pd_up = 1'b1;
    tick();
    clear_in();
    tick();
    chk("mid_code", 32'(code_bin), 32'd513);
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("mid_rst_valid", 32'(code_valid), 32'd0);
    chk("mid_rst_code", 32'(code_bin), 32'd512);
    chk("mid_rst_fg", 32'(f_gray), 32'h60);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_rel_low", 32'(code_valid), 32'd0);
    tick();
    chk("mid_rel_valid", 32'(code_valid), 32'd1);
    for (int i = 0; i < 8; i++) tick();

    pd_valid = 1'b1; pd_up = 1'b1; pd_dn = 1'b1;
    tick();
    clear_in();
    chk("both_valid", 32'(code_valid), 32'd1);
    tick();
    tick();
    chk("both_valid2", 32'(code_valid), 32'd1);
    chk("both_code", 32'(code_bin), 32'd512);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
